frame_state_writer: RTL and testbench

FRAME_STATE_WRITER -- requirements
Module: frame_state_writer

---
 rtl/frame_state_writer.sv | 131 +++++++++++++
 tb/tb_frame_state_writer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_state_writer.sv
// Purpose : double-buffered game-state registers; CPU fills a shadow bank, a commit
//           followed by screen_end copies it atomically into the visible bank.
// Latency : shadow writes land on the strobe edge; visible outputs update the cycle after screen_end.
// Backpressure: wr_ready drops from commit until the copy; writes and commits are dropped meanwhile.
//
// Ports:
//   clk, reset          100 MHz clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data  register write (addr 0-3 pipes, 4 bird, 5 score, 6 high score, 7 clear)
//   commit, screen_end  frame-complete pulse and between-frame pulse
//   wr_ready            high when writes are accepted (IDLE)
//   pipe1..pipe4, bird_top_left, current_score, high_score  visible bank
//   frame_count         number of completed copies (wraps)
//
// Build option: define HIGH_SCORE_AUTO_EN to make the copy store max(high_score, current_score)
// into both the visible and shadow high_score registers.

module frame_state_writer (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        commit,
    input  logic        screen_end,
    output logic        wr_ready,
    output logic [31:0] pipe1,
    output logic [31:0] pipe2,
    output logic [31:0] pipe3,
    output logic [31:0] pipe4,
    output logic [31:0] bird_top_left,
    output logic [31:0] current_score,
    output logic [31:0] high_score,
    output logic [15:0] frame_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam int NREG      = 7;
    localparam int IDX_SCORE = 5;
    localparam int IDX_HIGH  = 6;

    state_t      state_q, state_d;
    logic        wr_ready_q, wr_ready_d;
    logic [31:0] shadow_q  [0:NREG-1];
    logic [31:0] shadow_d  [0:NREG-1];
    logic [31:0] visible_q [0:NREG-1];
    logic [31:0] visible_d [0:NREG-1];
    logic [15:0] frame_count_q, frame_count_d;
    logic [31:0] high_max;

    always_comb begin
        state_d       = state_q;
        frame_count_d = frame_count_q;
        for (int i = 0; i < NREG; i++) begin
            shadow_d[i]  = shadow_q[i];
            visible_d[i] = visible_q[i];
        end
        high_max = (shadow_q[IDX_SCORE] > shadow_q[IDX_HIGH]) ? shadow_q[IDX_SCORE]
                                                               : shadow_q[IDX_HIGH];

        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    if (wr_addr == 3'd7) begin
                        // clear-game: everything except the high score
                        for (int i = 0; i < IDX_HIGH; i++) begin
                            shadow_d[i] = 32'd0;
                        end
                    end else begin
                        shadow_d[wr_addr] = wr_data;
                    end
                end
                // screen_end is deliberately ignored here: a copy needs a prior commit
                if (commit) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                // Shadow is frozen while ARMED, so the copy sees exactly the committed frame.
                if (screen_end) begin
                    for (int i = 0; i < NREG; i++) begin
                        visible_d[i] = shadow_q[i];
                    end
`ifdef HIGH_SCORE_AUTO_EN
                    visible_d[IDX_HIGH] = high_max;
                    shadow_d[IDX_HIGH]  = high_max;
`endif
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_ready_q    <= 1'b1;
            frame_count_q <= 16'd0;
            for (int i = 0; i < NREG; i++) begin
                shadow_q[i]  <= 32'd0;
                visible_q[i] <= 32'd0;
            end
        end else begin
            state_q       <= state_d;
            wr_ready_q    <= wr_ready_d;
            frame_count_q <= frame_count_d;
            for (int i = 0; i < NREG; i++) begin
                shadow_q[i]  <= shadow_d[i];
                visible_q[i] <= visible_d[i];
            end
        end
    end

    assign wr_ready      = wr_ready_q;
    assign pipe1         = visible_q[0];
    assign pipe2         = visible_q[1];
    assign pipe3         = visible_q[2];
    assign pipe4         = visible_q[3];
    assign bird_top_left = visible_q[4];
    assign current_score = visible_q[IDX_SCORE];
    assign high_score    = visible_q[IDX_HIGH];
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_frame_state_writer.sv
module tb_frame_state_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = 3'd0;
    logic [31:0] wr_data = 32'd0;
    logic        commit = 1'b0;
    logic        screen_end = 1'b0;
    logic        wr_ready;
    logic [31:0] pipe1, pipe2, pipe3, pipe4, bird_top_left, current_score, high_score;
    logic [15:0] frame_count;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    frame_state_writer dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .commit        (commit),
        .screen_end    (screen_end),
        .wr_ready      (wr_ready),
        .pipe1         (pipe1),
        .pipe2         (pipe2),
        .pipe3         (pipe3),
        .pipe4         (pipe4),
        .bird_top_left (bird_top_left),
        .current_score (current_score),
        .high_score    (high_score),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_sh  [7];
    logic [31:0] m_vis [7];
    bit          m_pending;   // a commit is waiting for screen_end
    logic [15:0] m_cnt;

    always @(posedge clk) begin
        logic [31:0] hs;
        if (reset) begin
            for (int i = 0; i < 7; i++) begin
                m_sh[i]  = 32'd0;
                m_vis[i] = 32'd0;
            end
            m_pending = 1'b0;
            m_cnt     = 16'd0;
        end else if (!m_pending) begin
            if (wr_en) begin
                if (wr_addr == 3'd7) begin
                    for (int i = 0; i < 6; i++) m_sh[i] = 32'd0;
                end else begin
                    m_sh[wr_addr] = wr_data;
                end
            end
            if (commit) m_pending = 1'b1;
        end else if (screen_end) begin
            hs = (m_sh[5] > m_sh[6]) ? m_sh[5] : m_sh[6];
`ifdef HIGH_SCORE_AUTO_EN
            m_sh[6] = hs;
`endif
            for (int i = 0; i < 7; i++) m_vis[i] = m_sh[i];
            m_cnt     = m_cnt + 16'd1;
            m_pending = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle once the DUT has been reset.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_wr_ready", {31'd0, wr_ready}, {31'd0, !m_pending});
            chk("m_pipe1", pipe1, m_vis[0]);
            chk("m_pipe2", pipe2, m_vis[1]);
            chk("m_pipe3", pipe3, m_vis[2]);
            chk("m_pipe4", pipe4, m_vis[3]);
            chk("m_bird", bird_top_left, m_vis[4]);
            chk("m_cur_score", current_score, m_vis[5]);
            chk("m_high_score", high_score, m_vis[6]);
            chk("m_frame_count", {16'd0, frame_count}, {16'd0, m_cnt});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1; cyc(); commit = 1'b0;
    endtask

    task automatic pulse_se();
        screen_end = 1'b1; cyc(); screen_end = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; cyc(); reset = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_hs;

        wait_n(2);
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset state
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst_pipe1", pipe1, 32'd0);
        chk("rst_high", high_score, 32'd0);
        chk("rst_count", {16'd0, frame_count}, 32'd0);

        // Basic write/commit/copy
        wr(3'd0, 32'd300);
        wr(3'd4, 32'h0064_0050);
        pulse_commit();
        chk("armed_wr_ready", {31'd0, wr_ready}, 32'd0);
        wait_n(3);
        chk("pre_copy_pipe1", pipe1, 32'd0);
        pulse_se();
        chk("copy_pipe1", pipe1, 32'd300);
        chk("copy_bird", bird_top_left, 32'h0064_0050);
        chk("copy_count", {16'd0, frame_count}, 32'd1);
        chk("copy_wr_ready", {31'd0, wr_ready}, 32'd1);

        // commit coinciding with screen_end in IDLE: copy waits for the next screen_end
        do_reset();
        wr(3'd0, 32'd7);
        commit = 1'b1; screen_end = 1'b1;
        cyc();
        commit = 1'b0; screen_end = 1'b0;
        chk("coinc_pipe1", pipe1, 32'd0);
        chk("coinc_count", {16'd0, frame_count}, 32'd0);
        wait_n(2);
        pulse_se();
        chk("coinc_late_pipe1", pipe1, 32'd7);
        chk("coinc_late_count", {16'd0, frame_count}, 32'd1);

        // Write while ARMED is dropped
        do_reset();
        wr(3'd5, 32'd4);
        pulse_commit();
        pulse_se();
        pulse_commit();
        wr(3'd5, 32'd9);
        chk("drop_wr_ready", {31'd0, wr_ready}, 32'd0);
        pulse_se();
        chk("drop_cur_score", current_score, 32'd4);
        chk("drop_count", {16'd0, frame_count}, 32'd2);

        // Write and commit in the same cycle: write is included
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'hABCD; commit = 1'b1;
        cyc();
        wr_en = 1'b0; commit = 1'b0;
        pulse_se();
        chk("wr_commit_pipe3", pipe3, 32'hABCD);

        // Clear-game keeps high score, clears the rest
        wr(3'd6, 32'd77);
        wr(3'd7, 32'hFFFF_FFFF);
        pulse_commit();
        pulse_se();
        chk("clear_pipe3", pipe3, 32'd0);
        chk("clear_high", high_score, 32'd77);

        // High-score handling
        do_reset();
        wr(3'd6, 32'd5);
        wr(3'd5, 32'd8);
        pulse_commit();
        pulse_se();
`ifdef HIGH_SCORE_AUTO_EN
        exp_hs = 32'd8;
`else
        exp_hs = 32'd5;
`endif
        chk("high_score_rule", high_score, exp_hs);

        // frame_count wrap: preload the counter rather than run 65535 frames
        do_reset();
        force dut.frame_count_d = 16'hFFFF;
        cyc();
        release dut.frame_count_d;
        m_cnt = 16'hFFFF;
        chk("preload_count", {16'd0, frame_count}, 32'h0000_FFFF);
        pulse_commit();
        pulse_se();
        chk("wrap_count", {16'd0, frame_count}, 32'd0);

        // Reset while ARMED abandons the commit; reset beats simultaneous wr_en/commit
        do_reset();
        wr(3'd0, 32'd1234);
        pulse_commit();
        reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'd55; commit = 1'b1;
        cyc();
        reset = 1'b0; wr_en = 1'b0; commit = 1'b0;
        pulse_se();
        chk("rst_armed_pipe1", pipe1, 32'd0);
        chk("rst_armed_count", {16'd0, frame_count}, 32'd0);
        chk("rst_armed_ready", {31'd0, wr_ready}, 32'd1);
        pulse_commit();
        pulse_se();
        chk("rst_prio_pipe2", pipe2, 32'd0);

        // Randomized traffic checked by the model every cycle
        for (int n = 0; n < 4000; n++) begin
            wr_en      = ($urandom_range(0, 1) == 1);
            wr_addr    = 3'($urandom_range(0, 7));
            wr_data    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
            commit     = ($urandom_range(0, 9) == 0);
            screen_end = ($urandom_range(0, 6) == 0);
            reset      = ($urandom_range(0, 199) == 0);
            cyc();
        end
        wr_en = 1'b0; commit = 1'b0; screen_end = 1'b0; reset = 1'b0;
        wait_n(2);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
